// File: rtl/prog_loader_if.sv
// Byte-stream ingress from the UART receiver and write port into progmem.
// The master drives received bytes in; the slave is the loader.
interface prog_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       write;
    logic [7:0] writeaddr;
    logic [7:0] writevalue;

    modport master (
        output rx_valid, rx_data,
        input  write, writeaddr, writevalue
    );

    modport slave (
        input  rx_valid, rx_data,
        output write, writeaddr, writevalue
    );
endinterface

// File: rtl/prog_loader.sv
// Framed program loader: SYNC, LEN, payload, CHK -> progmem writes.
// Holds the CPU in reset until a frame with a valid checksum has landed.
//
// state | meaning
// IDLE  | after reset, waiting for the first SYNC
// LEN   | SYNC seen, next byte is the payload length (0 = 256)
// DATA  | writing payload bytes into progmem
// CHECK | waiting for the checksum byte
// RUN   | program loaded, CPU released
// ERR   | oversize, bad checksum or inter-byte timeout
module prog_loader #(
    parameter int         SIZE    = 256,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 100000
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus,
    output logic         cpu_rst,
    output logic         done,
    output logic         error
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CHECK, S_RUN, S_ERR
    } state_t;

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [8:0]    SIZE_N  = 9'(SIZE);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t        state, state_nx;
    logic [8:0]    cnt;
    logic [8:0]    addr;
    logic [7:0]    sum;
    logic [TW-1:0] tcnt;

    logic [8:0] len_n;
    logic [8:0] addr_inc;
    logic       is_sync;
    logic       in_frame;
    logic       timed_out;

    assign len_n     = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
    assign addr_inc  = addr + 9'd1;
    assign is_sync   = bus.rx_valid && (bus.rx_data == SYNC);
    assign in_frame  = (state == S_LEN) || (state == S_DATA) || (state == S_CHECK);
    // The counter would hit TIMEOUT on this edge, so leave the frame now.
    assign timed_out = in_frame && !bus.rx_valid && (tcnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            addr           <= '0;
            sum            <= '0;
            tcnt           <= '0;
            bus.write      <= 1'b0;
            bus.writeaddr  <= '0;
            bus.writevalue <= '0;
        end else begin
            state     <= state_nx;
            bus.write <= 1'b0;
            if (!in_frame || bus.rx_valid || timed_out)
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;
            if (bus.rx_valid) begin
                case (state)
                    S_LEN: begin
                        cnt  <= len_n;
                        addr <= '0;
                        sum  <= '0;
                    end
                    S_DATA: begin
                        bus.write      <= 1'b1;
                        bus.writeaddr  <= addr[7:0];
                        bus.writevalue <= bus.rx_data;
                        sum            <= sum + bus.rx_data;
                        addr           <= addr_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_RUN, S_ERR: begin
                if (is_sync)
                    state_nx = S_LEN;
            end
            S_LEN: begin
                if (bus.rx_valid)
                    state_nx = (len_n > SIZE_N) ? S_ERR : S_DATA;
                else if (timed_out)
                    state_nx = S_ERR;
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    if (addr_inc == cnt)
                        state_nx = S_CHECK;
                end else if (timed_out) begin
                    state_nx = S_ERR;
                end
            end
            S_CHECK: begin
                if (bus.rx_valid)
                    state_nx = (bus.rx_data == sum) ? S_RUN : S_ERR;
                else if (timed_out)
                    state_nx = S_ERR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_rst = 1'b1;
        done    = 1'b0;
        error   = 1'b0;
        case (state)
            S_RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR: error = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed + randomized frames against a frame-level model of the loader.
// A second small instance (SIZE=16) is only released for the oversize case.
module tb_prog_loader;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum {O_IDLE, O_LOAD, O_RUN, O_ERR} outcome_t;

    logic       clk = 1'b0;
    logic       rst_big = 1'b0;
    logic       rst_small = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       big_cpu_rst, big_done, big_error;
    logic       small_cpu_rst, small_done, small_error;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_big[$];
    logic [15:0] got_small[$];

    prog_loader_if bus_big ();
    prog_loader_if bus_small ();

    assign bus_big.rx_valid   = rx_valid;
    assign bus_big.rx_data    = rx_data;
    assign bus_small.rx_valid = rx_valid;
    assign bus_small.rx_data  = rx_data;

    prog_loader #(.SIZE(256), .SYNC(SYNC), .TIMEOUT(8)) dut_big (
        .clk     (clk),
        .rst     (rst_big),
        .bus     (bus_big),
        .cpu_rst (big_cpu_rst),
        .done    (big_done),
        .error   (big_error)
    );

    prog_loader #(.SIZE(16), .SYNC(SYNC), .TIMEOUT(8)) dut_small (
        .clk     (clk),
        .rst     (rst_small),
        .bus     (bus_small),
        .cpu_rst (small_cpu_rst),
        .done    (small_done),
        .error   (small_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_big.write)
            got_big.push_back({bus_big.writeaddr, bus_big.writevalue});
        if (bus_small.write)
            got_small.push_back({bus_small.writeaddr, bus_small.writevalue});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input bit sml, input outcome_t o);
        logic cr, dn, er;
        cr = sml ? small_cpu_rst : big_cpu_rst;
        dn = sml ? small_done    : big_done;
        er = sml ? small_error   : big_error;
        chk({tag, "/cpu_rst"}, 32'(cr), 32'(o != O_RUN));
        chk({tag, "/done"},    32'(dn), 32'(o == O_RUN));
        chk({tag, "/error"},   32'(er), 32'(o == O_ERR));
    endtask

    task automatic check_writes(input string tag);
        #1;
        chk({tag, "/nwr"}, 32'(got_big.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_big.size(); i++)
            chk($sformatf("%s/wr%0d", tag, i), 32'(got_big[i]), 32'(exp_q[i]));
        exp_q.delete();
        got_big.delete();
    endtask

    // Frame-level reference: expected writes go to exp_q, result is the final status.
    function automatic outcome_t model_frame(input logic [7:0] len_b, input logic [7:0] pl[$],
                                             input logic [7:0] chk_b, input bit chk_sent,
                                             input int size);
        int n;
        logic [7:0] s;
        n = (len_b == 8'd0) ? 256 : int'(len_b);
        if (n > size)
            return O_ERR;
        s = 8'd0;
        for (int i = 0; i < pl.size(); i++) begin
            exp_q.push_back({8'(i), pl[i]});
            s = s + pl[i];
        end
        if (!chk_sent || pl.size() < n)
            return O_ERR;
        return (chk_b == s) ? O_RUN : O_ERR;
    endfunction

    task automatic put(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input int maxg);
        if (maxg > 0)
            idle(int'($urandom_range(0, maxg)));
    endtask

    task automatic send_frame(input string tag, input logic [7:0] len_b, input logic [7:0] pl[$],
                              input logic [7:0] chk_b, input int maxg);
        outcome_t o;
        o = model_frame(len_b, pl, chk_b, 1'b1, 256);
        put(SYNC);
        check_status({tag, "/sync"}, 1'b0, O_LOAD);
        gap(maxg);
        put(len_b);
        foreach (pl[i]) begin
            gap(maxg);
            put(pl[i]);
        end
        check_status({tag, "/prechk"}, 1'b0, O_LOAD);
        gap(maxg);
        put(chk_b);
        check_status({tag, "/end"}, 1'b0, o);
        check_writes(tag);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] s;
        outcome_t   o;
        int         n;

        // Reset values while reset is held
        idle(3);
        check_status("reset", 1'b0, O_IDLE);
        chk("reset/write",      32'(bus_big.write),      32'd0);
        chk("reset/writeaddr",  32'(bus_big.writeaddr),  32'd0);
        chk("reset/writevalue", 32'(bus_big.writevalue), 32'd0);
        rst_big = 1'b1;
        idle(2);

        // Non-SYNC bytes in IDLE are ignored
        put(8'h3C);
        put(8'h00);
        check_status("idle_ignore", 1'b0, O_IDLE);
        check_writes("idle_ignore");

        pl = {8'h10, 8'h20, 8'h30};
        send_frame("nominal", 8'h03, pl, 8'h60, 0);

        pl = {8'h01, 8'h02};
        send_frame("badchk", 8'h02, pl, 8'h04, 2);
        pl = {8'hFF};
        send_frame("recover", 8'h01, pl, 8'hFF, 2);

        for (int k = 0; k < 4; k++) begin
            n  = int'($urandom_range(1, 20));
            pl = {};
            s  = 8'd0;
            for (int i = 0; i < n; i++) begin
                pl.push_back(8'($urandom));
                s = s + pl[i];
            end
            if ($urandom_range(0, 1) == 1)
                s = s ^ 8'($urandom_range(1, 255));
            send_frame($sformatf("rand%0d", k), 8'(n), pl, s, 3);
        end

        // Back-to-back with SYNC as payload, then SYNC in RUN restarts
        pl = {8'hA5, 8'h5A};
        send_frame("b2b", 8'h02, pl, 8'hFF, 0);
        pl = {8'h42};
        send_frame("restart", 8'h01, pl, 8'h42, 0);

        // Oversize on the SIZE=16 instance; the big one times out in DATA
        rst_small = 1'b1;
        idle(1);
        put(SYNC);
        put(8'h20);
        check_status("oversize/small", 1'b1, O_ERR);
        check_status("oversize/big", 1'b0, O_LOAD);
        pl = {};
        o = model_frame(8'h20, pl, 8'h00, 1'b0, 256);
        idle(8);
        check_status("oversize/big_to", 1'b0, o);
        check_status("oversize/small2", 1'b1, O_ERR);
        chk("oversize/small_nwr", 32'(got_small.size()), 32'd0);
        check_writes("oversize");
        rst_small = 1'b0;

        // LEN=0 is 256 bytes; sum of 0..255 is 0x80
        pl = {};
        for (int i = 0; i < 256; i++)
            pl.push_back(8'(i));
        send_frame("wrap", 8'h00, pl, 8'h80, 1);

        // Inter-byte timeout, then late bytes are ignored
        put(SYNC);
        put(8'h04);
        put(8'h11);
        idle(7);
        check_status("timeout/pre", 1'b0, O_LOAD);
        idle(1);
        pl = {8'h11};
        o = model_frame(8'h04, pl, 8'h00, 1'b0, 256);
        check_status("timeout/hit", 1'b0, o);
        put(8'h22);
        put(8'h33);
        idle(2);
        check_status("timeout/late", 1'b0, O_ERR);
        check_writes("timeout");

        // Asynchronous reset between DATA bytes
        put(SYNC);
        put(8'h04);
        put(8'h01);
        put(8'h02);
        #2 rst_big = 1'b0;
        #1;
        check_status("areset", 1'b0, O_IDLE);
        chk("areset/write",      32'(bus_big.write),      32'd0);
        chk("areset/writeaddr",  32'(bus_big.writeaddr),  32'd0);
        chk("areset/writevalue", 32'(bus_big.writevalue), 32'd0);
        pl = {8'h01, 8'h02};
        o = model_frame(8'h04, pl, 8'h00, 1'b0, 256);
        check_writes("areset");
        @(negedge clk);
        rst_big = 1'b1;
        idle(1);
        pl = {8'h07};
        send_frame("post_reset", 8'h01, pl, 8'h07, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader upstream of progmem and cpu.
- Consumes framed bytes from the UART receiver and writes the payload into progmem through its write/writeaddr/writevalue port.
- Holds the CPU in reset while loading; releases it only after a valid checksum. Replaces $readmemh preload on hardware.

Parameters:
- SIZE, 256, progmem depth in bytes; legal range 2..256.
- SYNC, 8'hA5, frame start byte.
- TIMEOUT, 100000, maximum clk cycles allowed between bytes inside a frame; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- rx_data  input  8  received byte.
- write  output  1  progmem write enable; one-cycle pulse per payload byte.
- writeaddr  output  8  progmem write address.
- writevalue  output  8  progmem write data.
- cpu_rst  output  1  active-high reset to cpu; high whenever not in RUN.
- done  output  1  high in RUN.
- error  output  1  high in ERR.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, write=0, writeaddr=0, writevalue=0, cpu_rst=1, done=0, error=0. Also clears the byte counter, checksum accumulator, and timeout counter.
- Frame format: SYNC, LEN, LEN payload bytes, CHK.
  - LEN=0 means 256.
  - CHK = 8-bit sum, mod 256, of the payload bytes.
- IDLE: wait for rx_valid with rx_data==SYNC; go to LEN. All other bytes are ignored.
- LEN: on rx_valid, latch count n (0 -> 256).
  - If n>SIZE, go to ERR.
  - Otherwise clear addr and sum, then go to DATA.
- DATA: on each rx_valid, register write=1, writeaddr=addr, writevalue=rx_data on the next edge.
  - write is a single-cycle pulse.
  - Update sum += rx_data (wraps mod 256) and addr += 1.
  - After the n-th byte, go to CHECK.
  - A byte equal to SYNC inside DATA is payload; there is no resync.
- CHECK: on rx_valid, if rx_data==sum go to RUN, else go to ERR.
- RUN: cpu_rst=0 and done=1 from the edge that enters RUN. A SYNC byte in RUN goes to LEN; cpu_rst=1 and done=0 on that same edge. Other bytes are ignored.
- ERR: error=1 and cpu_rst=1. Partially written progmem contents are left as-is. A SYNC byte goes to LEN and clears error on that edge.
- Timeout:
  - In LEN/DATA/CHECK, the counter increments every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT goes to ERR.
  - In other states the counter is held at 0.
- Address width: writeaddr stays within 0..n-1; the internal addr counter is 9 bits so n=256 terminates correctly.
- Output registration: all outputs are registered with no combinational path from rx_* to outputs. Write latency is 1 cycle after the rx_valid edge.
- rx_valid is never back-pressured. The loader accepts one byte per cycle, including back-to-back strobes.
- Reset mid-frame: immediate return to the reset state. Already-written memory is not cleared.

Test Plan:
- Nominal load: bytes A5,03,10,20,30,60 -> three write pulses (addr0=10, addr1=20, addr2=30); cpu_rst falls and done rises on the edge after 60.
- Bad checksum: bytes A5,02,01,02,04 -> two writes, then error=1 and cpu_rst stays 1. A following frame A5,01,FF,FF -> error clears, then RUN.
- Oversize and wrap: with SIZE=16, A5,20 -> ERR with no writes. With SIZE=256, A5,00 plus 256 bytes of value k=i, CHK=80 -> last write at addr FF, then RUN.
- Timeout: with TIMEOUT=8, send A5,04,11 then idle 8 cycles -> error=1, no further writes. Late bytes are ignored until the next A5.
- Back-to-back and in-payload SYNC: rx_valid held high for A5,02,A5,5A,FF -> writes A5@0 and 5A@1, RUN reached. A5 in RUN restarts the load with cpu_rst=1 on the next edge.
- Async reset mid-DATA: drop rst between bytes -> all outputs take reset values immediately, without waiting for a clock edge; state returns to IDLE.
